// File: rtl/sif_bfe_pair_dispatch_pkg.sv
// rtl/sif_bfe_pair_dispatch_pkg.sv - shared constants, phase type and clog2 for the butterfly pair dispatcher
package sif_bfe_pair_dispatch_pkg;

  localparam int BFE_WIDTH = 16;

  typedef enum logic {
    PH_FILL = 1'b0,
    PH_PAIR = 1'b1
  } phase_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sif_bfe_pair_dispatch_if.sv
// rtl/sif_bfe_pair_dispatch_if.sv - sample input stream plus paired A/B operand streams
interface sif_bfe_pair_dispatch_if
  import sif_bfe_pair_dispatch_pkg::*;
#(
  parameter int WIDTH = BFE_WIDTH
);

  logic             in_vld;
  logic [WIDTH-1:0] in_dat;
  logic             in_rdy;
  logic             A_vld;
  logic [WIDTH-1:0] A_dat;
  logic             A_rdy;
  logic             B_vld;
  logic [WIDTH-1:0] B_dat;
  logic             B_rdy;

  modport master (
    output in_vld, in_dat, A_rdy, B_rdy,
    input  in_rdy, A_vld, A_dat, B_vld, B_dat
  );

  modport slave (
    input  in_vld, in_dat, A_rdy, B_rdy,
    output in_rdy, A_vld, A_dat, B_vld, B_dat
  );

endinterface

// File: rtl/sif_bfe_pair_dispatch_buf.sv
// rtl/sif_bfe_pair_dispatch_buf.sv - STRIDE-deep sample store, one write port, async read, no reset
module sif_bfe_pair_dispatch_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_dat_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_dat_i;
  end

  assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sif_bfe_pair_dispatch.sv
// rtl/sif_bfe_pair_dispatch.sv - pairs sample i with sample i+STRIDE of each 2*STRIDE block onto A/B operand streams
module sif_bfe_pair_dispatch
  import sif_bfe_pair_dispatch_pkg::*;
#(
  parameter int WIDTH  = BFE_WIDTH,
  parameter int STRIDE = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  sif_bfe_pair_dispatch_if.slave bus
);

  localparam int IDX_W = (clog2(STRIDE) > 1) ? clog2(STRIDE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STRIDE - 1);

  phase_e             phase_q, phase_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               out_vld_q, out_vld_d;
  logic [WIDTH-1:0]   a_dat_q, a_dat_d;
  logic [WIDTH-1:0]   b_dat_q, b_dat_d;
  logic [WIDTH-1:0]   buf_rd_dat;
  logic               in_rdy;
  logic               in_fire;
  logic               out_fire;

  // A and B transfer together, so both readies must be high to retire the pair
  assign out_fire = out_vld_q & bus.A_rdy & bus.B_rdy;
  assign in_rdy   = (phase_q == PH_FILL) | ~out_vld_q | out_fire;
  assign in_fire  = bus.in_vld & in_rdy;

  sif_bfe_pair_dispatch_buf #(
    .WIDTH (WIDTH),
    .DEPTH (STRIDE),
    .AW    (IDX_W)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (in_fire & (phase_q == PH_FILL)),
    .wr_addr_i (idx_q),
    .wr_dat_i  (bus.in_dat),
    .rd_addr_i (idx_q),
    .rd_dat_o  (buf_rd_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PH_FILL;
      idx_q     <= '0;
      out_vld_q <= 1'b0;
      a_dat_q   <= '0;
      b_dat_q   <= '0;
    end else begin
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      out_vld_q <= out_vld_d;
      a_dat_q   <= a_dat_d;
      b_dat_q   <= b_dat_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    idx_d     = idx_q;
    out_vld_d = out_vld_q;
    a_dat_d   = a_dat_q;
    b_dat_d   = b_dat_q;
    if (out_fire) out_vld_d = 1'b0;
    if (in_fire) begin
      if (idx_q == IDX_LAST) begin
        idx_d   = '0;
        phase_d = (phase_q == PH_FILL) ? PH_PAIR : PH_FILL;
      end else begin
        idx_d = idx_q + 1'b1;
      end
      // A load in PAIR overrides a same-cycle retire, keeping out_vld set
      if (phase_q == PH_PAIR) begin
        a_dat_d   = buf_rd_dat;
        b_dat_d   = bus.in_dat;
        out_vld_d = 1'b1;
      end
    end
  end

  assign bus.in_rdy = in_rdy;
  assign bus.A_vld  = out_vld_q;
  assign bus.B_vld  = out_vld_q;
  assign bus.A_dat  = a_dat_q;
  assign bus.B_dat  = b_dat_q;

endmodule

// File: tb/tb_sif_bfe_pair_dispatch.sv
// tb/tb_sif_bfe_pair_dispatch.sv - directed and random checks of the pair dispatcher at STRIDE=4 and STRIDE=1
module tb_sif_bfe_pair_dispatch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sif_bfe_pair_dispatch_if #(.WIDTH(16)) if4 ();
  sif_bfe_pair_dispatch_if #(.WIDTH(16)) if1 ();

  sif_bfe_pair_dispatch #(.WIDTH(16), .STRIDE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  sif_bfe_pair_dispatch #(.WIDTH(16), .STRIDE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int errors = 0;
  int checks = 0;

  // Reference: each accepted sample is stored by its position in the block;
  // sample S+i produces pair (blk[i], sample) which waits in order until retired.
  logic [31:0] expq0[$];
  logic [31:0] expq1[$];
  logic [15:0] blk[2][8];
  int          cnt[2];
  int          dut_pairs[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int id, input logic a_vld, input logic b_vld, input logic in_rdy,
                             input logic [15:0] a_dat, input logic [15:0] b_dat);
    chk($sformatf("d%0d_rst_A_vld", id), a_vld, 0);
    chk($sformatf("d%0d_rst_B_vld", id), b_vld, 0);
    chk($sformatf("d%0d_rst_A_dat", id), a_dat, 0);
    chk($sformatf("d%0d_rst_B_dat", id), b_dat, 0);
    chk($sformatf("d%0d_rst_in_rdy", id), in_rdy, 1);
    if (id == 0) expq0.delete(); else expq1.delete();
    cnt[id] = 0;
  endtask

  task automatic model_cycle(input int id, input int stride,
                             input logic a_vld, input logic b_vld, input logic in_rdy,
                             input logic [15:0] a_dat, input logic [15:0] b_dat,
                             input logic in_vld, input logic [15:0] in_dat,
                             input logic a_rdy, input logic b_rdy);
    logic        has;
    logic [31:0] front;
    logic        exp_rdy;
    has     = (id == 0) ? (expq0.size() != 0) : (expq1.size() != 0);
    front   = !has ? 32'h0 : ((id == 0) ? expq0[0] : expq1[0]);
    exp_rdy = (cnt[id] < stride) || !has || (a_rdy && b_rdy);
    chk($sformatf("d%0d_vld_equal", id), b_vld, a_vld);
    chk($sformatf("d%0d_A_vld", id), a_vld, has);
    chk($sformatf("d%0d_in_rdy", id), in_rdy, exp_rdy);
    if (has) begin
      chk($sformatf("d%0d_A_dat", id), a_dat, front[31:16]);
      chk($sformatf("d%0d_B_dat", id), b_dat, front[15:0]);
    end
    if (a_vld && a_rdy && b_rdy) dut_pairs[id]++;
    if (has && a_rdy && b_rdy) begin
      if (id == 0) void'(expq0.pop_front()); else void'(expq1.pop_front());
    end
    if (in_vld && exp_rdy) begin
      blk[id][cnt[id]] = in_dat;
      cnt[id]++;
      if (cnt[id] > stride) begin
        if (id == 0) expq0.push_back({blk[id][cnt[id]-1-stride], in_dat});
        else         expq1.push_back({blk[id][cnt[id]-1-stride], in_dat});
      end
      if (cnt[id] == 2 * stride) cnt[id] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset(0, if4.A_vld, if4.B_vld, if4.in_rdy, if4.A_dat, if4.B_dat);
      model_reset(1, if1.A_vld, if1.B_vld, if1.in_rdy, if1.A_dat, if1.B_dat);
    end else begin
      model_cycle(0, 4, if4.A_vld, if4.B_vld, if4.in_rdy, if4.A_dat, if4.B_dat,
                  if4.in_vld, if4.in_dat, if4.A_rdy, if4.B_rdy);
      model_cycle(1, 1, if1.A_vld, if1.B_vld, if1.in_rdy, if1.A_dat, if1.B_dat,
                  if1.in_vld, if1.in_dat, if1.A_rdy, if1.B_rdy);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [15:0] d);
    logic ok;
    ok = 1'b0;
    if4.in_vld = 1'b1;
    if4.in_dat = d;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (if4.in_rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    chk("send4_accept", ok, 1);
  endtask

  task automatic send1(input logic [15:0] d);
    logic ok;
    ok = 1'b0;
    if1.in_vld = 1'b1;
    if1.in_dat = d;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (if1.in_rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    chk("send1_accept", ok, 1);
  endtask

  task automatic idle(input int n);
    if4.in_vld = 1'b0;
    if1.in_vld = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst_n = 1'b0;
    if4.in_vld = 1'b0; if4.in_dat = '0; if4.A_rdy = 1'b1; if4.B_rdy = 1'b1;
    if1.in_vld = 1'b0; if1.in_dat = '0; if1.A_rdy = 1'b1; if1.B_rdy = 1'b1;
    dut_pairs[0] = 0; dut_pairs[1] = 0; cnt[0] = 0; cnt[1] = 0;
    repeat (3) step();
    chk("reset_in_rdy", if4.in_rdy, 1);
    chk("reset_A_vld", if4.A_vld, 0);
    rst_n = 1'b1;
    step();

    // Ordering: (1,5),(2,6),(3,7),(4,8)
    base = dut_pairs[0];
    for (int i = 1; i <= 8; i++) send4(16'(i));
    idle(3);
    chk("order_pair_count", dut_pairs[0] - base, 4);

    // Backpressure after the first pair
    base = dut_pairs[0];
    for (int i = 1; i <= 5; i++) send4(16'(i));
    if4.A_rdy = 1'b0; if4.B_rdy = 1'b0;
    if4.in_vld = 1'b1; if4.in_dat = 16'h6;
    repeat (3) begin
      @(negedge clk);
      chk("bp_A_vld", if4.A_vld, 1);
      chk("bp_A_dat", if4.A_dat, 16'h1);
      chk("bp_B_dat", if4.B_dat, 16'h5);
      chk("bp_in_rdy", if4.in_rdy, 0);
    end
    step();
    if4.A_rdy = 1'b1; if4.B_rdy = 1'b1;
    @(negedge clk);
    chk("bp_release_in_rdy", if4.in_rdy, 1);
    step();
    send4(16'h7);
    send4(16'h8);
    idle(3);
    chk("bp_pair_count", dut_pairs[0] - base, 4);

    // Mismatched readies hold the pair
    base = dut_pairs[0];
    for (int i = 1; i <= 5; i++) send4(16'(16'h30 + i));
    if4.A_rdy = 1'b1; if4.B_rdy = 1'b0;
    if4.in_vld = 1'b1; if4.in_dat = 16'h36;
    repeat (3) begin
      @(negedge clk);
      chk("mis_A_vld", if4.A_vld, 1);
      chk("mis_A_dat", if4.A_dat, 16'h31);
      chk("mis_B_dat", if4.B_dat, 16'h35);
    end
    step();
    if4.B_rdy = 1'b1;
    for (int i = 6; i <= 8; i++) send4(16'(16'h30 + i));
    idle(3);
    chk("mis_pair_count", dut_pairs[0] - base, 4);

    // Back-to-back blocks
    base = dut_pairs[0];
    for (int i = 16'h10; i <= 16'h1F; i++) send4(16'(i));
    idle(3);
    chk("b2b_pair_count", dut_pairs[0] - base, 8);

    // STRIDE=1
    base = dut_pairs[1];
    send1(16'hA); send1(16'hB); send1(16'hC); send1(16'hD);
    idle(3);
    chk("s1_pair_count", dut_pairs[1] - base, 2);

    // Reset mid-block
    send4(16'h1); send4(16'h2); send4(16'h3);
    idle(1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_A_vld", if4.A_vld, 0);
    chk("midrst_in_rdy", if4.in_rdy, 1);
    step();
    rst_n = 1'b1;
    step();
    base = dut_pairs[0];
    for (int i = 16'h21; i <= 16'h28; i++) send4(16'(i));
    idle(3);
    chk("midrst_pair_count", dut_pairs[0] - base, 4);

    // Random traffic on both instances
    for (int c = 0; c < 400; c++) begin
      if4.in_vld = ($urandom % 4) != 0;
      if4.in_dat = 16'($urandom);
      if4.A_rdy  = ($urandom % 3) != 0;
      if4.B_rdy  = ($urandom % 3) != 0;
      if1.in_vld = ($urandom % 4) != 0;
      if1.in_dat = 16'($urandom);
      if1.A_rdy  = ($urandom % 3) != 0;
      if1.B_rdy  = ($urandom % 3) != 0;
      step();
    end
    if4.A_rdy = 1'b1; if4.B_rdy = 1'b1;
    if1.A_rdy = 1'b1; if1.B_rdy = 1'b1;
    idle(5);
    chk("rand_drain_A_vld4", if4.A_vld, 0);
    chk("rand_drain_A_vld1", if1.A_vld, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
